// File: rtl/pcm_lin_to_log_enc.sv
// Sequential 13-bit sign-magnitude linear to 8-bit segmented log PCM compressor.
// Optional macro ALAW_EVEN_INVERT_EN applies even-bit inversion (XOR 8'h55) to the registered code.
module pcm_lin_to_log_enc #(
   parameter int unsigned SEG_MAX = 7,
   parameter int unsigned MAG_W   = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MAG_W:0] pcm_linear,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     pcm_log
);

`ifdef ALAW_EVEN_INVERT_EN
   localparam logic [7:0] InvMask = 8'h55;
`else
   localparam logic [7:0] InvMask = 8'h00;
`endif

   typedef enum logic [1:0] {StIdle, StSearch, StOut} state_e;

   state_e             r_state, w_state;
   logic               r_sign, w_sign;
   logic [MAG_W-1:0]   r_shift, w_shift;
   logic [2:0]         r_seg, w_seg;
   logic [7:0]         r_pcm_log, w_pcm_log;

   logic               w_lead_one;
   logic               w_last_seg;
   logic [2:0]         w_seg_code;
   logic [3:0]         w_step;

   assign w_lead_one = r_shift[MAG_W-1];
   assign w_last_seg = (r_seg == 3'd1);
   // Reaching segment 1 without a leading one means the sample belongs to segment 0.
   assign w_seg_code = w_lead_one ? r_seg : 3'd0;
   assign w_step     = r_shift[MAG_W-2 -: 4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_sign    <= 1'b0;
         r_shift   <= '0;
         r_seg     <= 3'd0;
         r_pcm_log <= 8'h00;
      end else begin
         r_state   <= w_state;
         r_sign    <= w_sign;
         r_shift   <= w_shift;
         r_seg     <= w_seg;
         r_pcm_log <= w_pcm_log;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_sign    = r_sign;
      w_shift   = r_shift;
      w_seg     = r_seg;
      w_pcm_log = r_pcm_log;
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_sign  = pcm_linear[MAG_W];
               w_shift = pcm_linear[MAG_W-1:0];
               w_seg   = 3'(SEG_MAX);
               w_state = StSearch;
            end
         end
         StSearch: begin
            if (w_lead_one || w_last_seg) begin
               w_pcm_log = {r_sign, w_seg_code, w_step} ^ InvMask;
               w_state   = StOut;
            end else begin
               w_shift = {r_shift[MAG_W-2:0], 1'b0};
               w_seg   = r_seg - 3'd1;
            end
         end
         StOut: begin
            if (out_ready) begin
               w_state = StIdle;
            end
         end
         default: w_state = StIdle;
      endcase
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StOut);
   assign pcm_log   = r_pcm_log;

endmodule
